// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: the FSM state encoding,
// the default register-index width and the NOP encoding used when IF/ID is flushed.
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    // All-zero word decodes as sll $0,$0,0, the canonical NOP of the pipe CPU
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags when the load in EX writes a register that the
// instruction in ID reads. Register 0 is hard-wired, so it never creates a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              lu_hit
);

    // Pure comparator, shared with the forwarding unit
    always_comb begin
        lu_hit = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipe CPU. A small FSM sequences load-use stalls,
// taken-branch flushes and data-memory wait freezes. All control outputs are decoded
// combinationally from the state and the current inputs so they act in the same cycle.
// Two saturating counters record stalled cycles and IF/ID flush cycles.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] IFID_rs_i,
    input  logic [REG_AW-1:0] IFID_rt_i,
    input  logic              IDEX_MemRead_i,
    input  logic [REG_AW-1:0] IDEX_rt_i,
    input  logic              EX_br_taken_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ready_i,
    input  logic              perf_clr_i,
    output logic              PC_Write_o,
    output logic              pc_src_o,
    output logic              IFID_Write_o,
    output logic              IFID_Flush_o,
    output logic              IDEX_Flush_o,
    output logic              stage_en_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // The flush counter only ever holds FLUSH_CYCLES-1 or less
    localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

    hz_state_e       state_reg, state_next;
    logic [FC_W-1:0] fcnt_reg, fcnt_next;
    logic            ret_reg, ret_next;

    logic lu_hit;
    logic mem_wait;
    logic flush_phase;
    logic lu_allowed;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_lu (
        .ex_mem_read (IDEX_MemRead_i),
        .ex_rt       (IDEX_rt_i),
        .id_rs       (IFID_rs_i),
        .id_rt       (IFID_rt_i),
        .lu_hit      (lu_hit)
    );

    // Qualifiers shared by the decode below
    always_comb begin
        mem_wait    = dmem_req_i && !dmem_ready_i;
        // A frozen BR_FLUSH resumes its flush on the ready cycle
        flush_phase = (state_reg == ST_BR_FLUSH) || ((state_reg == ST_MEM_WAIT) && ret_reg);
        // The cycle right after a load-use stall must not stall again on the same pair
        lu_allowed  = (state_reg != ST_LU_STALL);
    end

    // State register, flush counter and return flag
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= ST_RUN;
            fcnt_reg  <= '0;
            ret_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
            ret_reg   <= ret_next;
        end
    end

    // Next-state and Mealy output decode; priority mem_wait > flush phase > branch > load-use
    always_comb begin
        PC_Write_o   = 1'b1;
        pc_src_o     = 1'b0;
        IFID_Write_o = 1'b1;
        IFID_Flush_o = 1'b0;
        IDEX_Flush_o = 1'b0;
        stage_en_o   = 1'b1;
        state_next   = ST_RUN;
        fcnt_next    = fcnt_reg;
        ret_next     = 1'b0;

        if (mem_wait) begin
            // Freeze everything; a BR_FLUSH cycle still presents its flush request
            PC_Write_o   = 1'b0;
            IFID_Write_o = 1'b0;
            stage_en_o   = 1'b0;
            IFID_Flush_o = (state_reg == ST_BR_FLUSH);
            state_next   = ST_MEM_WAIT;
            if (state_reg == ST_BR_FLUSH) begin
                ret_next = 1'b1;
            end else if (state_reg == ST_MEM_WAIT) begin
                ret_next = ret_reg;
            end
        end else if (flush_phase) begin
            // Wrong-path cycles: branch and load-use in ID/EX are ignored
            IFID_Flush_o = 1'b1;
            if (fcnt_reg <= FC_ONE) begin
                fcnt_next  = '0;
                state_next = ST_RUN;
            end else begin
                fcnt_next  = fcnt_reg - FC_ONE;
                state_next = ST_BR_FLUSH;
            end
        end else if (EX_br_taken_i) begin
            pc_src_o     = 1'b1;
            IFID_Flush_o = 1'b1;
            IDEX_Flush_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                fcnt_next  = FC_LOAD;
                state_next = ST_BR_FLUSH;
            end
        end else if (lu_hit && lu_allowed) begin
            PC_Write_o   = 1'b0;
            IFID_Write_o = 1'b0;
            IDEX_Flush_o = 1'b1;
            state_next   = ST_LU_STALL;
        end
    end

    // Saturating performance counters: index 0 counts stalls, index 1 counts IF/ID flushes
    logic [1:0]       perf_inc;
    logic [CNT_W-1:0] perf_cnt [2];

    assign perf_inc = {IFID_Flush_o, !PC_Write_o};

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [CNT_W-1:0] cnt_reg;

        // Clear wins over increment; hold at all-ones instead of wrapping
        always_ff @(posedge clk_i) begin
            if (!rst_i || perf_clr_i) begin
                cnt_reg <= '0;
            end else if (perf_inc[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end

        assign perf_cnt[gi] = cnt_reg;
    end

    assign stall_cnt_o = perf_cnt[0];
    assign flush_cnt_o = perf_cnt[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       idex_memread, ex_br, dmem_req, dmem_ready, perf_clr;
    logic       pc_write, pc_src, ifid_write, ifid_flush, idex_flush, stage_en;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit m_valid    = 1'b0;
    int m_flush_left = 0;   // wrong-path flush cycles still owed
    bit m_waiting  = 1'b0;  // previous cycle was a memory freeze
    bit m_lu_block = 1'b0;  // previous cycle was a load-use stall
    int m_stall    = 0;
    int m_flush    = 0;

    pipe_hazard_ctrl #(
        .REG_AW       (5),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IFID_rs_i      (ifid_rs),
        .IFID_rt_i      (ifid_rt),
        .IDEX_MemRead_i (idex_memread),
        .IDEX_rt_i      (idex_rt),
        .EX_br_taken_i  (ex_br),
        .dmem_req_i     (dmem_req),
        .dmem_ready_i   (dmem_ready),
        .perf_clr_i     (perf_clr),
        .PC_Write_o     (pc_write),
        .pc_src_o       (pc_src),
        .IFID_Write_o   (ifid_write),
        .IFID_Flush_o   (ifid_flush),
        .IDEX_Flush_o   (idex_flush),
        .stage_en_o     (stage_en),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_idle();
        idex_memread = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        ex_br = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1; perf_clr = 1'b0;
    endtask

    // One clock cycle: compare against the model at the falling edge, advance the model,
    // then step past the rising edge.
    task automatic tick();
        bit mw, lu;
        bit e_pcw, e_src, e_ifw, e_iff, e_idf, e_en;
        @(negedge clk_i);
        mw = dmem_req && !dmem_ready;
        lu = idex_memread && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
        e_pcw = 1; e_ifw = 1; e_en = 1; e_src = 0; e_iff = 0; e_idf = 0;
        if (mw) begin
            e_pcw = 0; e_ifw = 0; e_en = 0;
            e_iff = (m_flush_left > 0) && !m_waiting;
        end else if (m_flush_left > 0) begin
            e_iff = 1;
        end else if (ex_br) begin
            e_src = 1; e_iff = 1; e_idf = 1;
        end else if (lu && !m_lu_block) begin
            e_pcw = 0; e_ifw = 0; e_idf = 1;
        end
        if (m_valid) begin
            chk("PC_Write",   16'(pc_write),   16'(e_pcw));
            chk("pc_src",     16'(pc_src),     16'(e_src));
            chk("IFID_Write", 16'(ifid_write), 16'(e_ifw));
            chk("IFID_Flush", 16'(ifid_flush), 16'(e_iff));
            chk("IDEX_Flush", 16'(idex_flush), 16'(e_idf));
            chk("stage_en",   16'(stage_en),   16'(e_en));
            chk("stall_cnt",  16'(stall_cnt),  16'(m_stall));
            chk("flush_cnt",  16'(flush_cnt),  16'(m_flush));
        end
        if (!rst_i) begin
            m_flush_left = 0; m_waiting = 0; m_lu_block = 0; m_stall = 0; m_flush = 0;
            m_valid = 1;
        end else begin
            if (perf_clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e_pcw && m_stall < CMAX) m_stall++;
                if (e_iff && m_flush < CMAX)  m_flush++;
            end
            if (mw) begin
                m_waiting = 1; m_lu_block = 0;
            end else begin
                m_waiting = 0;
                if (m_flush_left > 0) begin
                    m_flush_left--; m_lu_block = 0;
                end else if (ex_br) begin
                    m_flush_left = FC - 1; m_lu_block = 0;
                end else if (lu && !m_lu_block) begin
                    m_lu_block = 1;
                end else begin
                    m_lu_block = 0;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_counters();
        perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    endtask

    initial begin
        set_idle();
        rst_i = 1'b0;
        #1;
        // Reset for two cycles
        tick(); tick();
        rst_i = 1'b1;
        #1;
        chk("reset_pc_write", 16'(pc_write), 16'd1);
        chk("reset_stage_en", 16'(stage_en), 16'd1);
        chk("reset_ifid_flush", 16'(ifid_flush), 16'd0);
        chk("reset_stall_cnt", 16'(stall_cnt), 16'd0);
        chk("reset_flush_cnt", 16'(flush_cnt), 16'd0);
        tick();

        // Load-use on rs
        clear_counters();
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        #1;
        chk("lu_pc_write", 16'(pc_write), 16'd0);
        chk("lu_idex_flush", 16'(idex_flush), 16'd1);
        tick();
        set_idle();
        #1;
        chk("lu_next_pc_write", 16'(pc_write), 16'd1);
        chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);
        tick();

        // Load to $0 never stalls
        idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        #1;
        chk("lu_r0_pc_write", 16'(pc_write), 16'd1);
        tick();
        set_idle();
        tick();

        // Taken branch with two flush cycles
        clear_counters();
        ex_br = 1'b1;
        #1;
        chk("br_pc_src", 16'(pc_src), 16'd1);
        chk("br_ifid_flush", 16'(ifid_flush), 16'd1);
        chk("br_idex_flush", 16'(idex_flush), 16'd1);
        tick();
        ex_br = 1'b0;
        #1;
        chk("br_second_flush", 16'(ifid_flush), 16'd1);
        tick();
        #1;
        chk("br_done_flush", 16'(ifid_flush), 16'd0);
        chk("br_flush_cnt", 16'(flush_cnt), 16'd2);
        tick();

        // Branch and load-use together: branch wins
        clear_counters();
        ex_br = 1'b1; idex_memread = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7;
        #1;
        chk("brlu_pc_src", 16'(pc_src), 16'd1);
        chk("brlu_pc_write", 16'(pc_write), 16'd1);
        tick();
        set_idle();
        tick();
        tick();
        chk("brlu_stall_cnt", 16'(stall_cnt), 16'd0);

        // Three-cycle memory wait with the branch held in EX
        clear_counters();
        ex_br = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_stage_en", 16'(stage_en), 16'd0);
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        chk("mw_ready_pc_src", 16'(pc_src), 16'd1);
        chk("mw_ready_ifid_flush", 16'(ifid_flush), 16'd1);
        chk("mw_ready_idex_flush", 16'(idex_flush), 16'd1);
        chk("mw_stall_cnt", 16'(stall_cnt), 16'd3);
        tick();
        set_idle();
        tick();
        tick();

        // Saturation after 20 stall cycles, then clear during a stall
        clear_counters();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_cnt", 16'(stall_cnt), 16'd15);
        perf_clr = 1'b1;
        tick();
        chk("clr_stall_cnt", 16'(stall_cnt), 16'd0);
        set_idle();
        tick();

        // Reset in the middle of a branch flush discards the remainder
        ex_br = 1'b1;
        tick();
        ex_br = 1'b0; rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        chk("rst_mid_flush", 16'(ifid_flush), 16'd0);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst_i        = ($urandom_range(0, 199) != 0);
            idex_memread = 1'($urandom_range(0, 1));
            idex_rt      = 5'($urandom_range(0, 7));
            ifid_rs      = 5'($urandom_range(0, 7));
            ifid_rt      = 5'($urandom_range(0, 7));
            ex_br        = ($urandom_range(0, 5) == 0);
            dmem_req     = ($urandom_range(0, 3) == 0);
            dmem_ready   = ($urandom_range(0, 2) != 0);
            perf_clr     = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
